multicycle_ctrl: RTL

Moore-style control FSM that sequences the shared-ALU, shared-memory multicycle RISC-V datapath (RV32I subset: lw, sw, R-type, I-type ALU, beq, jal). Each instruction is broken into Fetch/Decode/Execute/Memory/Writeback steps. The block drives the datapath mux selects and write enables each cycle, and stalls on a memory-ready handshake. It also flags illegal opcodes and counts retired instructions. ALU function decode stays in the existing ALU decoder, which consumes ALUOp.

---
 rtl/multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Moore-style control FSM for the shared-ALU, shared-memory multicycle RV32I
// datapath (lw, sw, R-type, I-type ALU, beq, jal). Every instruction is split
// into Fetch / Decode / Execute / Memory / Writeback steps. This block drives
// the datapath mux selects and write enables each cycle, stalls on the unified
// memory's ready handshake, flags illegal opcodes and counts retired
// instructions. ALU function decode is done downstream by the ALU decoder,
// which consumes ALUOp.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//   MEM_WAIT_EN  1 = honour MemReady, 0 = memory always completes in one cycle
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; forces FETCH, clears counters
//   op         in   opcode field of the instruction register
//   Zero       in   ALU zero flag (branch compare result)
//   MemReady   in   unified memory completes its access this cycle
//   PCWrite    out  PC register enable
//   AdrSrc     out  memory address select: 0 PC, 1 Result
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register / OldPC enable
//   RegWrite   out  register file write enable
//   ResultSrc  out  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  00 PC, 01 OldPC, 10 RegA
//   ALUSrcB    out  00 RegB, 01 ImmExt, 10 constant 4
//   ALUOp      out  00 add, 01 sub/compare, 10 funct-decoded
//   ImmSrc     out  immediate format, decoded straight from op
//   Illegal    out  sticky illegal-opcode flag
//   Instret    out  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             Illegal,
    output logic [CNT_W-1:0] Instret
);

    // State encoding (binary)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    // Supported opcodes
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Mux select encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       mem_rdy;
    logic       retire;

    // Raw enables before the reset override
    logic       pcwrite_raw;
    logic       memwrite_raw;
    logic       irwrite_raw;
    logic       regwrite_raw;

    // With waiting disabled the memory is assumed to finish every access in
    // the cycle it is issued.
    assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_rdy) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYP:      state_nxt = S_EXECR;
                    OP_IALU:      state_nxt = S_EXECI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // op is held by the IR, so only lw/sw can reach this state;
                // anything else recovers to FETCH rather than wedging.
                if (op == OP_LW)      state_nxt = S_MEMREAD;
                else if (op == OP_SW) state_nxt = S_MEMWRITE;
                else                  state_nxt = S_FETCH;
            end
            S_MEMREAD: begin
                if (mem_rdy) state_nxt = S_MEMWB;
            end
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: begin
                if (mem_rdy) state_nxt = S_FETCH;
            end
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BEQ:      state_nxt = S_FETCH;
            // jal still has to write the link address (PC+4) into rd
            S_JAL:      state_nxt = S_ALUWB;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Moore output decode; every signal defaults to 0 in each state
    always_comb begin
        pcwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_REGB;
        ALUOp        = ALU_ADD;
        case (state)
            S_FETCH: begin
                // PC+4 computed and written back through ALUResult; both PC
                // and IR only load once the instruction word has arrived.
                AdrSrc      = 1'b0;
                ALUSrcA     = SRCA_PC;
                ALUSrcB     = SRCB_FOUR;
                ALUOp       = ALU_ADD;
                ResultSrc   = RES_ALURES;
                irwrite_raw = mem_rdy;
                pcwrite_raw = mem_rdy;
            end
            S_DECODE: begin
                // Branch/jump target OldPC+imm parked in ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
            end
            S_MEMREAD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe held for the whole stall; the memory commits on the
                // cycle it raises MemReady.
                ResultSrc    = RES_ALUOUT;
                AdrSrc       = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_REGB;
                ALUOp   = ALU_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc    = RES_ALUOUT;
                regwrite_raw = 1'b1;
            end
            S_BEQ: begin
                // Compare rs1-rs2 while the target sits in ALUOut
                ALUSrcA     = SRCA_REGA;
                ALUSrcB     = SRCB_REGB;
                ALUOp       = ALU_SUB;
                ResultSrc   = RES_ALUOUT;
                pcwrite_raw = Zero;
            end
            S_JAL: begin
                // PC <- target from ALUOut; ALU meanwhile forms OldPC+4 for rd
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                ALUOp       = ALU_ADD;
                ResultSrc   = RES_ALUOUT;
                pcwrite_raw = 1'b1;
            end
            default: begin
                // TRAP and unused encodings: everything stays 0
            end
        endcase
    end

    // Architectural write enables are held off for the whole reset pulse,
    // even though the state register already reads FETCH.
    assign PCWrite  = pcwrite_raw  & ~reset;
    assign MemWrite = memwrite_raw & ~reset;
    assign IRWrite  = irwrite_raw  & ~reset;
    assign RegWrite = regwrite_raw & ~reset;

    // Immediate format comes straight from the opcode
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // An instruction retires on the step that hands control back to FETCH
    // from its final state. jal retires through ALUWB, so it is counted once.
    always_comb begin
        retire = 1'b0;
        if (state_nxt == S_FETCH) begin
            case (state)
                S_MEMWB, S_ALUWB, S_BEQ: retire = 1'b1;
                S_MEMWRITE:              retire = mem_rdy;
                default:                 retire = 1'b0;
            endcase
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Instret <= '0;
        end else if (retire) begin
            Instret <= Instret + CNT_W'(1);
        end
    end

    // Sticky illegal flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Illegal <= 1'b0;
        end else if ((state == S_DECODE) && (state_nxt == S_TRAP)) begin
            Illegal <= 1'b1;
        end
    end

endmodule
